uart_char_presenter: RTL and testbench

//   Sits between the UART receiver and the message comparator. Buffers bytes arriving on
//   rx_data/rx_done in a small FIFO and presents each one on curr_char for exactly HOLD_CYCLES

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 70 +++++++
 rtl/uart_char_presenter.sv | 107 ++++++++++
 tb/tb_uart_char_presenter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared character constants and presenter FSM encodings for the UART receive path.
// The comparator imports the same character constants.
package uart_pkg;

    localparam logic [7:0] CHAR_IDLE  = 8'h00;
    localparam logic [7:0] CHAR_LOSE  = 8'h4C;
    localparam logic [7:0] CHAR_READY = 8'h52;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO between the UART receiver and the presenter.
// A push while full is accepted only when a pop happens at the same edge.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // full/empty are registered copies of the post-edge count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_char_presenter.sv
// Presents each buffered UART byte on curr_char for HOLD_CYCLES clocks followed by
// GAP_CYCLES clocks of the idle character, so downstream sees every byte exactly once.
module uart_char_presenter
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] curr_char,
    output logic       char_valid,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             pop;
    logic             full;
    logic [7:0]       head;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_done),
        .pop   (pop),
        .din   (rx_data),
        .dout  (head),
        .full  (full),
        .empty (fifo_empty)
    );

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_GAP:  pop = (cnt == '0) && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            curr_char  <= CHAR_IDLE;
            char_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (rx_done && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state      <= ST_HOLD;
                        curr_char  <= head;
                        char_valid <= 1'b1;
                        cnt        <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state      <= ST_GAP;
                        curr_char  <= CHAR_IDLE;
                        char_valid <= 1'b0;
                        cnt        <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        if (pop) begin
                            state      <= ST_HOLD;
                            curr_char  <= head;
                            char_valid <= 1'b1;
                            cnt        <= HOLD_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    curr_char  <= CHAR_IDLE;
                    char_valid <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_char_presenter.sv
// Bench for uart_char_presenter: two instances (default and HOLD=3/GAP=1) against a
// queue-and-timeline reference model, plus a vector table and hand-written corner cases.
module tb_uart_char_presenter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;

    logic [7:0] c1, c2;
    logic       v1, v2, e1, e2, o1, o2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_char_presenter #(.DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .curr_char(c1), .char_valid(v1), .fifo_empty(e1), .overflow(o1)
    );

    uart_char_presenter #(.DEPTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .curr_char(c2), .char_valid(v2), .fifo_empty(e2), .overflow(o2)
    );

    // Model: pending bytes as a packed queue, plus the age of the current slot
    // (cycles since its byte was popped; -1 when idle).
    typedef struct {
        logic [3:0][7:0] q;
        int              n;
        int              age;
        logic [7:0]      b;
        logic            ovf;
    } model_t;

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic [7:0] exp_char;
        logic       exp_valid;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    model_t m1, m2;
    vec_t   tbl[$];

    function automatic model_t mreset();
        model_t r;
        r.q   = '0;
        r.n   = 0;
        r.age = -1;
        r.b   = 8'h00;
        r.ovf = 1'b0;
        return r;
    endfunction

    function automatic model_t step(input model_t m, input logic done, input logic [7:0] d,
                                    input int hold, input int gap);
        model_t r;
        bit     can_pop;
        r = m;
        can_pop = (m.n > 0) && (m.age < 0 || m.age == hold + gap - 1);
        if (can_pop) begin
            r.b   = m.q[0];
            r.q   = m.q >> 8;
            r.n   = m.n - 1;
            r.age = 0;
        end else if (m.age < 0 || m.age == hold + gap - 1) begin
            r.age = -1;
        end else begin
            r.age = m.age + 1;
        end
        if (done) begin
            if (m.n < 4 || can_pop) begin
                r.q[r.n] = d;
                r.n      = r.n + 1;
            end else begin
                r.ovf = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] m_char(input model_t m, input int hold);
        return (m.age >= 0 && m.age < hold) ? m.b : 8'h00;
    endfunction

    function automatic logic m_valid(input model_t m, input int hold);
        return (m.age >= 0 && m.age < hold);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models(input string tag);
        chk({tag, " char1"},  c1,            m_char(m1, 1));
        chk({tag, " valid1"}, {7'b0, v1},    {7'b0, m_valid(m1, 1)});
        chk({tag, " empty1"}, {7'b0, e1},    {7'b0, (m1.n == 0)});
        chk({tag, " ovf1"},   {7'b0, o1},    {7'b0, m1.ovf});
        chk({tag, " char2"},  c2,            m_char(m2, 3));
        chk({tag, " valid2"}, {7'b0, v2},    {7'b0, m_valid(m2, 3)});
        chk({tag, " empty2"}, {7'b0, e2},    {7'b0, (m2.n == 0)});
        chk({tag, " ovf2"},   {7'b0, o2},    {7'b0, m2.ovf});
    endtask

    task automatic cycle(input logic d, input logic [7:0] data);
        rx_done = d;
        rx_data = data;
        @(posedge clk);
        m1 = step(m1, d, data, 1, 2);
        m2 = step(m2, d, data, 3, 1);
        #1;
        check_models("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask

    // Asserted between clock edges so the async path alone must clear the outputs.
    task automatic do_reset();
        rx_done = 1'b0;
        rst = 1'b1;
        #1;
        m1 = mreset();
        m2 = mreset();
        chk("rst char1",  c1, 8'h00);
        chk("rst valid1", {7'b0, v1}, 8'h00);
        chk("rst empty1", {7'b0, e1}, 8'h01);
        chk("rst ovf1",   {7'b0, o1}, 8'h00);
        chk("rst char2",  c2, 8'h00);
        chk("rst valid2", {7'b0, v2}, 8'h00);
        chk("rst empty2", {7'b0, e2}, 8'h01);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic add(input logic d, input logic [7:0] data, input logic [7:0] ch,
                       input logic v, input logic e, input logic o);
        vec_t t;
        t.done = d; t.data = data; t.exp_char = ch;
        t.exp_valid = v; t.exp_empty = e; t.exp_ovf = o;
        tbl.push_back(t);
    endtask

    initial begin
        m1 = mreset();
        m2 = mreset();
        #2;
        do_reset();

        // Single 'L', then 'R','L','x' on consecutive clocks (default instance).
        add(1, 8'h4C, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h4C, 1, 1, 0);
        add(0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h00, 0, 1, 0);
        add(1, 8'h52, 8'h00, 0, 0, 0);
        add(1, 8'h4C, 8'h52, 1, 0, 0);
        add(1, 8'h78, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h4C, 1, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h78, 1, 1, 0);
        add(0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h00, 0, 1, 0);
        foreach (tbl[i]) begin
            cycle(tbl[i].done, tbl[i].data);
            chk($sformatf("vec%0d char", i),  c1, tbl[i].exp_char);
            chk($sformatf("vec%0d valid", i), {7'b0, v1}, {7'b0, tbl[i].exp_valid});
            chk($sformatf("vec%0d empty", i), {7'b0, e1}, {7'b0, tbl[i].exp_empty});
            chk($sformatf("vec%0d ovf", i),   {7'b0, o1}, {7'b0, tbl[i].exp_ovf});
        end
        idle(8);

        // Fill to 4, then strobe exactly on a pop edge: accepted; next strobe overflows.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i));
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h16);
        chk("full+pop ovf",   {7'b0, o1}, 8'h00);
        chk("full+pop empty", {7'b0, e1}, 8'h00);
        cycle(1'b1, 8'h17);
        chk("full no-pop ovf", {7'b0, o1}, 8'h01);
        idle(30);

        // Long burst: overflow sets and stays set through the drain.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i));
        chk("burst ovf", {7'b0, o1}, 8'h01);
        idle(40);
        chk("burst ovf sticky", {7'b0, o1}, 8'h01);
        chk("burst drained",    {7'b0, e1}, 8'h01);

        // Reset mid-HOLD (second instance) with two bytes still queued.
        cycle(1'b1, 8'h52);
        cycle(1'b1, 8'h4C);
        cycle(1'b1, 8'h78);
        chk("pre-rst hold2", c2, 8'h52);
        #2;
        do_reset();
        idle(12);
        chk("post-rst quiet1", c1, 8'h00);
        chk("post-rst quiet2", c2, 8'h00);

        // HOLD=3, GAP=1: 'L' for three clocks, one idle clock, then idle.
        cycle(1'b1, 8'h4C);
        cycle(1'b0, 8'h00); chk("h3 e1 char", c2, 8'h4C);
        cycle(1'b0, 8'h00); chk("h3 e2 char", c2, 8'h4C);
        cycle(1'b0, 8'h00); chk("h3 e3 char", c2, 8'h4C);
        chk("h3 e3 valid", {7'b0, v2}, 8'h01);
        cycle(1'b0, 8'h00); chk("h3 gap char", c2, 8'h00);
        chk("h3 gap valid", {7'b0, v2}, 8'h00);
        cycle(1'b0, 8'h00); chk("h3 idle char", c2, 8'h00);
        idle(4);

        // Randomized traffic, alternating dense and sparse phases.
        for (int blk = 0; blk < 12; blk++) begin
            int thresh;
            thresh = (blk % 2 == 0) ? 60 : 12;
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom_range(0, 99) < thresh), 8'($urandom));
            end
            if (blk == 5) do_reset();
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
